// File: rtl/tile_map_responder.sv
// tile_map_responder: registered tile bit map with row loader and zero-latency solidity query
module tile_map_responder #(
  parameter int TILE_COLS  = 20,
  parameter int TILE_ROWS  = 15,
  parameter int TILE_SHIFT = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [9:0]           x,
  input  logic [9:0]           y,
  output logic                 blockType,
  input  logic                 load_start,
  input  logic [TILE_COLS-1:0] load_data,
  input  logic                 load_valid,
  output logic                 load_ready,
  output logic                 map_ready,
  output logic                 load_done
);
  localparam int RW = $clog2(TILE_ROWS);
  localparam int CW = $clog2(TILE_COLS);
  localparam int XL = TILE_COLS << TILE_SHIFT;
  localparam int YL = TILE_ROWS << TILE_SHIFT;
  typedef enum logic [1:0] {CLEAR, IDLE, LOAD} state_t;
  state_t               r_state, w_state_nxt;
  logic [RW-1:0]        r_cnt, w_cnt_nxt, w_row;
  logic [CW-1:0]        w_col;
  logic [TILE_COLS-1:0] r_map [TILE_ROWS];
  logic                 r_done, w_last, w_adv;
  // next state: CLEAR and LOAD both walk the row counter, CLEAR every cycle, LOAD on each handshake
  always_comb begin
    w_last      = r_cnt == RW'(TILE_ROWS - 1);
    w_adv       = r_state == CLEAR || (r_state == LOAD && load_valid);
    w_state_nxt = w_adv ? (w_last ? IDLE : r_state) : (r_state == IDLE && load_start) ? LOAD : r_state;
    w_cnt_nxt   = w_adv ? (w_last ? '0 : r_cnt + 1'b1) : (r_state == IDLE) ? '0 : r_cnt;
  end
  // state, row counter and the one-cycle done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= r_state == LOAD && w_adv && w_last;
    end
  end
  // map rows: zeroed during CLEAR, filled from load_data during LOAD, untouched in IDLE
  always_ff @(posedge clk) begin
    for (int r = 0; r < TILE_ROWS; r++)
      if (!reset && w_adv && r_cnt == RW'(r))
        r_map[r] <= r_state == LOAD ? load_data : '0;
  end
  // query: anything off-map or while the map is not stable reads as solid
  always_comb begin
    w_col     = CW'(x >> TILE_SHIFT);
    w_row     = RW'(y >> TILE_SHIFT);
    blockType = r_state != IDLE || 32'(x) >= XL || 32'(y) >= YL || r_map[w_row][w_col];
  end
  assign load_ready = r_state == LOAD;
  assign map_ready  = r_state == IDLE;
  assign load_done  = r_done;
endmodule
